scanline_pos_gen: RTL and testbench
===================================

// Module: scanline_pos_gen
// PURPOSE
//  Produces the per-line scanline position word (sl_rel_pos) for the scanline emulation stage in the PPU.
//  Tracks output lines against source lines with a fractional vertical step accumulator.
//  Forwards video, syncs and DE one cycle delayed, so sl_rel_pos_o is aligned with them.
//  Sits between the vertical scaler output and the scanline emulation input.
// PARAMETERS
//  SYNC_ACT_HIGH  1    1: HSYNC/VSYNC active high; 0: active low (used only for edge detection)
//  MAX_LINES      1200 output active lines per frame; lines beyond this are not counted
// PORTS
//  VCLK_i          in   1    video clock; single clock domain
//  VRST_i          in   1    reset, synchronous, active-high
//  HSYNC_i         in   1    horizontal sync from scaler
//  VSYNC_i         in   1    vertical sync from scaler
//  DE_i            in   1    data enable from scaler
//  vdata_i         in   3*color_width_o   RGB video (`VDATA_O_CO_SLICE)
//  vstep_i         in   9    source-line fraction per output line, Q1.8; 9'h100 = 1:1
//  vphase_init_i   in   8    accumulator value loaded at frame start
//  field_i         in   1    0 = even field, 1 = odd field (sampled at frame start)
//  HSYNC_o         out  1    HSYNC_i delayed by 1 cycle
//  VSYNC_o         out  1    VSYNC_i delayed by 1 cycle
//  DE_o            out  1    DE_i delayed by 1 cycle
//  vdata_o         out  3*color_width_o   vdata_i delayed by 1 cycle
//  sl_rel_pos_o    out  8    position in source line; 8'h80 = boundary between two source lines
// BEHAVIOUR
//  Reset: all outputs 0, sl_rel_pos_o = 8'h80, acc = 0, line_cnt = 0, state = WAIT_FRAME.
//  Reset is sampled every cycle, so asserting it mid-frame takes effect on the next edge.
//  Passthrough: HSYNC_o, VSYNC_o, DE_o and vdata_o register their inputs; fixed latency of 1 cycle.
//  Edge detection is registered on the raw inputs.
//   - vs_start = active VSYNC edge (polarity from SYNC_ACT_HIGH).
//   - de_fall = DE 1->0.
//  step_eff = (vstep_i == 0) ? 9'h100 : vstep_i, so a step of 0 never freezes the accumulator.
//  sl_rel_pos_o = acc[7:0] + step_eff[8:1] + 8'h80, computed mod 256; it samples the line centre.
//   - sl_rel_pos_o is registered.
//   - It changes only in the cycle after a state-machine update.
//   - It is constant for the whole active line, including the DE_o window.
//  FSM states:
//   WAIT_FRAME -> on vs_start: acc <= vphase_init_i, line_cnt <= 0, go to WAIT_LINE.
//   WAIT_LINE  -> on DE_i rising edge: go to ACTIVE.
//   ACTIVE     -> on de_fall: go to BLANK.
//   BLANK      -> on DE_i rising edge: go to ACTIVE.
//   Any state  -> on vs_start: frame-start load, then WAIT_LINE. vs_start has the highest priority.
//  On de_fall in ACTIVE, if line_cnt < MAX_LINES:
//   - acc <= (acc + step_eff) mod 256; carries out of bit 7 are discarded (source-line wrap).
//   - line_cnt <= line_cnt + 1.
//  If line_cnt == MAX_LINES, acc and line_cnt hold until the next vs_start.
//  If vs_start and de_fall occur in the same cycle, the frame-start load wins and no step is added.
//  If DE is already high at vs_start, that line is treated as the first line of the frame.
// CONFIGURATION
//  SCANLINE_POS_GEN_FIELD_OFS_EN defined:
//   - At frame start with field_i = 1: acc <= vphase_init_i + step_eff[8:1] (8-bit wrap).
//   - This moves odd-field scanlines by half an output line.
//  Macro undefined: field_i is ignored and the load is always vphase_init_i.
// STRUCTURE
//  Shared package: color_width_o and the VDATA_O_* slices already live in n64adv_vparams.vh.
//  Add the FSM state encoding localparams (ST_WAIT_FRAME, ST_WAIT_LINE, ST_ACTIVE, ST_BLANK) to the same package.
//  One sub-module, sl_phase_acc, holds acc, line_cnt, the MAX_LINES clamp and the step_eff/offset adder.
//  The top level holds the edge detectors, the FSM and the passthrough registers.
// TESTING
//  1. vstep=0x080, init=0x00, 4 lines -> sl_rel_pos_o per line = C0,40,C0,40.
//  2. vstep=0x100, init=0x00 -> every line 0x00; vstep=0 gives the same result as 0x100.
//  3. vstep=0x055, init=0xF0 -> wrap without error: F0+2A+80=9A, then 45+2A+80=EF.
//  4. vs_start in the same cycle as de_fall -> acc = init and the next line uses the init value.
//  5. VRST_i high mid-line for 1 cycle -> next cycle all outputs 0, sl_rel_pos_o = 80, FSM in WAIT_FRAME.
//  6. With FIELD_OFS_EN, vstep=0x080, field=1 -> first line is 0x00 (40+40+80); field=0 gives C0.
//  Every case checks that HSYNC/VSYNC/DE/vdata outputs equal the inputs delayed by exactly 1 cycle.

Source files
------------

// File: rtl/scanline_pos_gen_pkg.sv
// Shared definitions for the scanline position generator: video word width,
// FSM state encoding and the effective vertical step helper.
package scanline_pos_gen_pkg;

  localparam int color_width_o = 8;
  localparam int VDATA_W       = 3 * color_width_o;

  localparam logic [7:0] SL_POS_BOUNDARY = 8'h80;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_WAIT_LINE  = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_BLANK      = 2'd3
  } sl_state_t;

  // A zero step would freeze the accumulator, so it is treated as 1:1.
  function automatic logic [8:0] step_eff_f(input logic [8:0] vstep);
    return (vstep == 9'd0) ? 9'h100 : vstep;
  endfunction

endpackage

// File: rtl/scanline_pos_gen_phase_acc.sv
// sl_phase_acc: fractional source-line accumulator with per-frame line clamp.
// SCANLINE_POS_GEN_FIELD_OFS_EN adds a half-step offset to the odd-field load.
module sl_phase_acc
  import scanline_pos_gen_pkg::*;
#(
  parameter int MAX_LINES = 1200,
  parameter int CNT_W     = $clog2(MAX_LINES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [8:0]       vstep,
  input  logic [7:0]       vphase_init,
  input  logic             field,
  output logic [7:0]       acc,
  output logic [7:0]       pos,
  output logic [CNT_W-1:0] line_cnt
);

  logic [8:0] step_eff;
  logic [7:0] half_step;
  logic [7:0] load_val;

  assign step_eff  = step_eff_f(vstep);
  assign half_step = step_eff[8:1];

`ifdef SCANLINE_POS_GEN_FIELD_OFS_EN
  assign load_val = field ? (vphase_init + half_step) : vphase_init;
`else
  logic unused_field;
  assign unused_field = field;
  assign load_val     = vphase_init;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      line_cnt <= '0;
    end else if (load) begin
      acc      <= load_val;
      line_cnt <= '0;
    end else if (step && (line_cnt < CNT_W'(MAX_LINES))) begin
      // Only the fractional part is kept; carries mark a new source line.
      acc      <= acc + step_eff[7:0];
      line_cnt <= line_cnt + CNT_W'(1);
    end
  end

  // Sample the centre of the output line rather than its top edge.
  assign pos = acc + half_step + SL_POS_BOUNDARY;

endmodule

// File: rtl/scanline_pos_gen.sv
// scanline_pos_gen: per-line scanline position word aligned with the
// one-cycle-delayed video stream. Optional macro: SCANLINE_POS_GEN_FIELD_OFS_EN.
module scanline_pos_gen
  import scanline_pos_gen_pkg::*;
#(
  parameter bit SYNC_ACT_HIGH = 1'b1,
  parameter int MAX_LINES     = 1200
) (
  input  logic               VCLK_i,
  input  logic               VRST_i,
  input  logic               HSYNC_i,
  input  logic               VSYNC_i,
  input  logic               DE_i,
  input  logic [VDATA_W-1:0] vdata_i,
  input  logic [8:0]         vstep_i,
  input  logic [7:0]         vphase_init_i,
  input  logic               field_i,
  output logic               HSYNC_o,
  output logic               VSYNC_o,
  output logic               DE_o,
  output logic [VDATA_W-1:0] vdata_o,
  output logic [7:0]         sl_rel_pos_o,
  output sl_state_t          dbg_state_o
);

  localparam int CNT_W = $clog2(MAX_LINES + 1);

  sl_state_t        state, state_nxt;
  logic             vs_act, vs_act_prev;
  logic             vs_start, de_rise, de_fall;
  logic             load, step, upd_q;
  logic [7:0]       acc, pos;
  logic [CNT_W-1:0] line_cnt;

  // The passthrough registers double as the previous-cycle edge history.
  assign vs_act      = SYNC_ACT_HIGH ? VSYNC_i : ~VSYNC_i;
  assign vs_act_prev = SYNC_ACT_HIGH ? VSYNC_o : ~VSYNC_o;
  assign vs_start    = vs_act & ~vs_act_prev;
  assign de_rise     = DE_i & ~DE_o;
  assign de_fall     = ~DE_i & DE_o;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    if (vs_start) begin
      // A line already in progress at frame start counts as line 0.
      load      = 1'b1;
      state_nxt = DE_i ? ST_ACTIVE : ST_WAIT_LINE;
    end else begin
      case (state)
        ST_WAIT_FRAME: state_nxt = ST_WAIT_FRAME;
        ST_WAIT_LINE,
        ST_BLANK: begin
          if (de_rise) state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (de_fall) begin
            step      = 1'b1;
            state_nxt = ST_BLANK;
          end
        end
        default: state_nxt = ST_WAIT_FRAME;
      endcase
    end
  end

  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      state        <= ST_WAIT_FRAME;
      HSYNC_o      <= 1'b0;
      VSYNC_o      <= 1'b0;
      DE_o         <= 1'b0;
      vdata_o      <= '0;
      upd_q        <= 1'b0;
      sl_rel_pos_o <= SL_POS_BOUNDARY;
    end else begin
      state   <= state_nxt;
      HSYNC_o <= HSYNC_i;
      VSYNC_o <= VSYNC_i;
      DE_o    <= DE_i;
      vdata_o <= vdata_i;
      upd_q   <= load | step;
      // Latch only after an accumulator update so the word stays fixed per line.
      if (upd_q) sl_rel_pos_o <= pos;
    end
  end

  assign dbg_state_o = state;

  sl_phase_acc #(
    .MAX_LINES (MAX_LINES),
    .CNT_W     (CNT_W)
  ) u_phase_acc (
    .clk         (VCLK_i),
    .rst         (VRST_i),
    .load        (load),
    .step        (step),
    .vstep       (vstep_i),
    .vphase_init (vphase_init_i),
    .field       (field_i),
    .acc         (acc),
    .pos         (pos),
    .line_cnt    (line_cnt)
  );

endmodule

// File: tb/tb_scanline_pos_gen.sv
// Randomized scoreboard bench for scanline_pos_gen: expected line positions come
// from a per-frame arithmetic model; passthrough is checked against last-cycle inputs.
module tb_scanline_pos_gen;
  import scanline_pos_gen_pkg::*;

  localparam int MAX_L = 6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, hs, vs, de, field;
  logic [VDATA_W-1:0] vdata;
  logic [8:0]         vstep;
  logic [7:0]         vinit;
  logic               hs_o, vs_o, de_o;
  logic [VDATA_W-1:0] vdata_o;
  logic [7:0]         sl_o;
  sl_state_t          st_o;

  scanline_pos_gen #(
    .SYNC_ACT_HIGH (1'b1),
    .MAX_LINES     (MAX_L)
  ) dut (
    .VCLK_i        (clk),
    .VRST_i        (rst),
    .HSYNC_i       (hs),
    .VSYNC_i       (vs),
    .DE_i          (de),
    .vdata_i       (vdata),
    .vstep_i       (vstep),
    .vphase_init_i (vinit),
    .field_i       (field),
    .HSYNC_o       (hs_o),
    .VSYNC_o       (vs_o),
    .DE_o          (de_o),
    .vdata_o       (vdata_o),
    .sl_rel_pos_o  (sl_o),
    .dbg_state_o   (st_o)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one frame = base phase + k whole steps, clamped at MAX_L lines
  bit         in_frame = 1'b0;
  int         line_idx = 0;
  int         m_se     = 256;
  int         m_base   = 0;

  task automatic model_frame_start();
    in_frame = 1'b1;
    line_idx = 0;
    m_se     = (vstep == 9'd0) ? 256 : int'(vstep);
    m_base   = int'(vinit);
`ifdef SCANLINE_POS_GEN_FIELD_OFS_EN
    if (field) m_base = (m_base + m_se / 2) % 256;
`endif
  endtask

  function automatic logic [7:0] expected_pos();
    int k, a;
    if (!in_frame) return 8'h80;
    k = (line_idx < MAX_L) ? line_idx : MAX_L;
    a = (m_base + k * m_se) % 256;
    return 8'((a + m_se / 2 + 128) % 256);
  endfunction

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic v);
    de    = d;
    vs    = v;
    hs    = 1'($urandom_range(0, 1));
    vdata = VDATA_W'($urandom);
    if (d && !rst) exp_q.push_back(expected_pos());
    tick();
  endtask

  task automatic set_params(input logic [8:0] s, input logic [7:0] i, input logic f);
    vstep = s;
    vinit = i;
    field = f;
  endtask

  task automatic start_frame(input logic [8:0] s, input logic [7:0] i, input logic f);
    set_params(s, i, f);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    model_frame_start();
    repeat (3) drive(1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0);
  endtask

  task automatic run_line(input int len, input bit vs_at_end);
    for (int i = 0; i < len; i++) drive(1'b1, 1'b0);
    if (vs_at_end) begin
      model_frame_start();
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      repeat (3) drive(1'b0, 1'b0);
    end else begin
      line_idx++;
      repeat ($urandom_range(2, 5)) drive(1'b0, 1'b0);
    end
  endtask

  task automatic reset_mid_line(input int len);
    for (int i = 0; i < len; i++) begin
      if (i == len / 2) begin
        rst      = 1'b1;
        in_frame = 1'b0;
        drive(1'b1, 1'b0);
        rst = 1'b0;
      end else begin
        drive(1'b1, 1'b0);
      end
    end
    repeat (3) drive(1'b0, 1'b0);
  endtask

  // monitor: outputs at this negedge reflect inputs seen at the previous one
  logic               p_rst, p_hs, p_vs, p_de;
  logic [VDATA_W-1:0] p_vdata;
  bit                 p_valid = 1'b0;

  always @(negedge clk) begin
    if (p_valid) begin
      if (p_rst) begin
        check("rst_passthru", {hs_o, vs_o, de_o, vdata_o}, '0);
        check("rst_sl_pos", sl_o, 8'h80);
        check("rst_state", st_o, ST_WAIT_FRAME);
      end else begin
        check("passthru", {hs_o, vs_o, de_o, vdata_o}, {p_hs, p_vs, p_de, p_vdata});
      end
      if (de_o) begin
        if (exp_q.size() == 0) check("sl_pos_unexpected_de", 1, 0);
        else check("sl_pos", sl_o, exp_q.pop_front());
      end
    end
    p_rst   = rst;
    p_hs    = hs;
    p_vs    = vs;
    p_de    = de;
    p_vdata = vdata;
    p_valid = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; vdata = '0;
    set_params(9'h100, 8'h00, 1'b0);
    repeat (4) tick();
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0);

    // half step: C0,40,C0,40
    start_frame(9'h080, 8'h00, 1'b0);
    repeat (4) run_line($urandom_range(3, 8), 1'b0);
    // 1:1 and zero step
    start_frame(9'h100, 8'h00, 1'b0);
    repeat (3) run_line($urandom_range(3, 8), 1'b0);
    start_frame(9'h000, 8'h00, 1'b0);
    repeat (3) run_line($urandom_range(3, 8), 1'b0);
    // wrap: 9A, EF, ...
    start_frame(9'h055, 8'hF0, 1'b0);
    repeat (4) run_line($urandom_range(3, 8), 1'b0);
    // frame start coincident with DE fall
    start_frame(9'h080, 8'h10, 1'b0);
    repeat (2) run_line(4, 1'b0);
    set_params(9'h060, 8'h20, 1'b0);
    run_line(4, 1'b1);
    repeat (3) run_line(4, 1'b0);
    // line clamp
    start_frame(9'h0C3, 8'h37, 1'b0);
    repeat (MAX_L + 3) run_line($urandom_range(3, 6), 1'b0);
    // reset mid-line, then lines before any frame start
    reset_mid_line(8);
    repeat (2) run_line(4, 1'b0);
    // field offset
    start_frame(9'h080, 8'h00, 1'b1);
    repeat (2) run_line(4, 1'b0);
    start_frame(9'h080, 8'h00, 1'b0);
    repeat (2) run_line(4, 1'b0);

    // random frames
    for (int f = 0; f < 20; f++) begin
      start_frame(9'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      for (int l = 0; l < $urandom_range(1, MAX_L + 2); l++) begin
        if ($urandom_range(0, 9) == 0) begin
          set_params(9'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
          run_line($urandom_range(2, 8), 1'b1);
        end else begin
          run_line($urandom_range(2, 8), 1'b0);
        end
      end
    end

    repeat (4) drive(1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
